// File: rtl/address_sequencer.sv
// Bounded address stream (linear, wrap, Galois LFSR, constant) with start/abort/done run control.
// Defining ADDRESS_SEQUENCER_STALL_COUNT_EN adds a saturating backpressure counter output, stall_count.
module address_sequencer #(
    parameter int WIDTH       = 48,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       range_start,
    input  logic [WIDTH-1:0]       range_end,
    input  logic [WIDTH-1:0]       range_increment,
    input  logic [WIDTH-1:0]       lfsr_seed,
    input  logic [WIDTH-1:0]       lfsr_taps,
    input  logic [WIDTH-1:0]       lfsr_mask,
    input  logic [WIDTH-1:0]       final_mask,
    input  logic [COUNT_WIDTH-1:0] count,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_address,
    output logic                   busy,
    output logic                   done
`ifdef ADDRESS_SEQUENCER_STALL_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_LINEAR = 2'd0,
        MODE_WRAP   = 2'd1,
        MODE_LFSR   = 2'd2,
        MODE_CONST  = 2'd3
    } mode_e;

    state_e                 state_q;
    mode_e                  mode_q;
    logic [WIDTH-1:0]       range_start_q;
    logic [WIDTH-1:0]       range_end_q;
    logic [WIDTH-1:0]       increment_q;
    logic [WIDTH-1:0]       taps_q;
    logic [WIDTH-1:0]       lfsr_mask_q;
    logic [WIDTH-1:0]       final_mask_q;
    logic [WIDTH-1:0]       address_q;
    logic [WIDTH-1:0]       out_address_q;
    logic [COUNT_WIDTH-1:0] remaining_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   done_q;

    logic [WIDTH-1:0]       address_d;
    logic [WIDTH-1:0]       load_address;
    logic [WIDTH:0]         wrap_sum;
    logic                   beat_fire;

    assign beat_fire    = valid_q & out_ready;
    assign load_address = (mode_e'(mode) == MODE_LFSR) ? lfsr_seed : range_start;
    assign wrap_sum     = {1'b0, address_q} + {1'b0, increment_q};

    // NOTE: always_comb assigns a default first so no path leaves address_d unassigned (no latch).
    always_comb begin
        address_d = address_q;
        case (mode_q)
            MODE_LINEAR: address_d = address_q + increment_q;
            MODE_WRAP: begin
                if (wrap_sum[WIDTH] || (wrap_sum[WIDTH-1:0] > range_end_q)) begin
                    address_d = range_start_q;
                end else begin
                    address_d = wrap_sum[WIDTH-1:0];
                end
            end
            MODE_LFSR: begin
                address_d = ((address_q >> 1) ^ (address_q[0] ? taps_q : '0)) & lfsr_mask_q;
            end
            default: address_d = address_q;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            mode_q        <= MODE_LINEAR;
            range_start_q <= '0;
            range_end_q   <= '0;
            increment_q   <= '0;
            taps_q        <= '0;
            lfsr_mask_q   <= '0;
            final_mask_q  <= '0;
            address_q     <= '0;
            out_address_q <= '0;
            remaining_q   <= '0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q        <= mode_e'(mode);
                        range_start_q <= range_start;
                        range_end_q   <= range_end;
                        increment_q   <= range_increment;
                        taps_q        <= lfsr_taps;
                        lfsr_mask_q   <= lfsr_mask;
                        final_mask_q  <= final_mask;
                        address_q     <= load_address;
                        out_address_q <= load_address & final_mask;
                        remaining_q   <= count;
                        busy_q        <= 1'b1;
                        if (count == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            valid_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (beat_fire) begin
                        address_q     <= address_d;
                        out_address_q <= address_d & final_mask_q;
                        remaining_q   <= remaining_q - COUNT_WIDTH'(1);
                    end
                    // Abort outranks completion: a final beat accepted with abort gives no done.
                    if (abort) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (beat_fire && (remaining_q == COUNT_WIDTH'(1))) begin
                        state_q <= S_DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid   = valid_q;
    assign out_address = out_address_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef ADDRESS_SEQUENCER_STALL_COUNT_EN
    logic [COUNT_WIDTH-1:0] stall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            stall_q <= '0;
        end else if (valid_q && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + COUNT_WIDTH'(1);
        end
    end

    assign stall_count = stall_q;
`endif

endmodule
